// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry, widths, colour type and small helpers for the fb reader.
// Latency: n/a (declarations and combinational helper functions only).
// Backpressure: n/a.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int PIPE_LAT  = 3;
  localparam int FB_AW     = 17;

  localparam int XY_W      = 10;
  localparam int IDX_W     = 8;
  localparam int COL_W     = 12;
  localparam int PAL_DEPTH = 256;
  localparam int BAR_W     = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic [FB_AW-1:0] fb_addr_t;

  // Half-resolution framebuffer address: y'*320 + x' built as (y'<<8)+(y'<<6)+x'.
  // Inputs are the already-halved coordinates; largest result is 239*320+319 = 76799.
  function automatic fb_addr_t fb_addr_calc(input logic [XY_W-2:0] xh,
                                            input logic [XY_W-2:0] yh);
    fb_addr_t ys;
    fb_addr_t xs;
    ys = fb_addr_t'(yh);
    xs = fb_addr_t'(xh);
    return (ys << 8) + (ys << 6) + xs;
  endfunction

  // Colour-bar number for a screen column: eight equal bars across the active width.
  function automatic logic [BAR_W-1:0] bar_index(input logic [XY_W-1:0] x);
    logic [BAR_W-1:0] bar;
    bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (x >= XY_W'(i * (H_ACTIVE / 8))) begin
        bar = BAR_W'(i);
      end
    end
    return bar;
  endfunction

endpackage

// File: rtl/vga_palette.sv
// vga_palette: 256 x 12-bit colour lookup table, one write port, one registered read port.
// Latency: read data registered 1 i_clk after i_re; a write is visible to reads from the next i_clk.
// Backpressure: none; writes accepted every cycle, read register holds while i_re is low.
module vga_palette
  import vga_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [COL_W-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output rgb444_t           o_rdata
);

  logic [COL_W-1:0] mem_q [PAL_DEPTH];
  logic [COL_W-1:0] rdata_q;
  logic [COL_W-1:0] rdata_d;

  // Read register only moves on a read; otherwise it keeps the last colour
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) begin
      rdata_d = mem_q[i_raddr];
    end
  end

  // Storage and read register; no reset so contents survive a pipeline reset.
  // Read samples the array before this edge's write lands, giving old data on a collision.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    rdata_q <= rdata_d;
  end

  assign o_rdata = rgb444_t'(rdata_q);

endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: pixel position -> framebuffer read -> palette index -> RGB444 with matched syncs.
// Latency: 3 pixel strobes from i_x/i_y/i_hs/i_vs/i_active to o_r/o_g/o_b/o_hs/o_vs.
// Backpressure: none; pipeline advances only when i_pix_stb=1 and holds otherwise.
// Build option: VGA_FB_TEST_PATTERN_EN adds i_test_mode (eight colour bars instead of fb data).
module vga_fb_reader
  import vga_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
`ifdef VGA_FB_TEST_PATTERN_EN
  input  logic              i_test_mode,
`endif
  input  logic              i_pix_stb,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_active,
  input  logic [XY_W-1:0]   i_x,
  input  logic [XY_W-1:0]   i_y,
  output logic [FB_AW-1:0]  o_fb_addr,
  output logic              o_fb_rd,
  input  logic [IDX_W-1:0]  i_fb_data,
  input  logic              i_pal_we,
  input  logic [IDX_W-1:0]  i_pal_addr,
  input  logic [COL_W-1:0]  i_pal_data,
  output logic [3:0]        o_r,
  output logic [3:0]        o_g,
  output logic [3:0]        o_b,
  output logic              o_hs,
  output logic              o_vs
);

  // Stage 1: address, read pulse, pixel tags
  fb_addr_t          addr1_q, addr1_d;
  logic              rd_q, rd_d;
  logic              act1_q, act1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
`ifdef VGA_FB_TEST_PATTERN_EN
  logic              tm1_q, tm1_d;
  logic [BAR_W-1:0]  bar1_q, bar1_d;
`endif

  // Framebuffer return path
  logic              rd_dly_q, rd_dly_d;
  logic [IDX_W-1:0]  fb_cap_q, fb_cap_d;

  // Stage 2: palette index and valid tag
  logic [IDX_W-1:0]  idx2_q, idx2_d;
  logic              vld2_q, vld2_d;
  logic              hs2_q, hs2_d;
  logic              vs2_q, vs2_d;

  // Stage 3: valid tag and syncs aligned with the palette read register
  logic              vld3_q, vld3_d;
  logic              hs3_q, hs3_d;
  logic              vs3_q, vs3_d;

  rgb444_t           pal_rgb;
  rgb444_t           rgb_out;

  // The halved address drops the low coordinate bits; they are intentionally unused here
  logic              unused_xy_lsb;
  assign unused_xy_lsb = i_x[0] ^ i_y[0];

  // Stage 1: latch the pixel and raise a one-clock read for active pixels
  always_comb begin
    addr1_d = addr1_q;
    act1_d  = act1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    rd_d    = 1'b0;
`ifdef VGA_FB_TEST_PATTERN_EN
    tm1_d   = tm1_q;
    bar1_d  = bar1_q;
`endif
    if (i_pix_stb) begin
      addr1_d = fb_addr_calc(i_x[XY_W-1:1], i_y[XY_W-1:1]);
      act1_d  = i_active;
      hs1_d   = i_hs;
      vs1_d   = i_vs;
      rd_d    = i_active;
`ifdef VGA_FB_TEST_PATTERN_EN
      tm1_d   = i_test_mode;
      bar1_d  = bar_index(i_x);
      rd_d    = i_active & ~i_test_mode;
`endif
    end
  end

  // Return path: the byte arrives one clock after o_fb_rd and is captured on the clock after that.
  // fb_cap_d bypasses the capture so a strobe landing on that same edge still sees the new byte.
  always_comb begin
    rd_dly_d = rd_q;
    fb_cap_d = fb_cap_q;
    if (rd_dly_q) begin
      fb_cap_d = i_fb_data;
    end
  end

  // Stage 2: form the palette index; inactive pixels become index 0 tagged blank
  always_comb begin
    idx2_d = idx2_q;
    vld2_d = vld2_q;
    hs2_d  = hs2_q;
    vs2_d  = vs2_q;
    if (i_pix_stb) begin
      vld2_d = act1_q;
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      idx2_d = '0;
      if (act1_q) begin
        idx2_d = fb_cap_d;
`ifdef VGA_FB_TEST_PATTERN_EN
        if (tm1_q) begin
          idx2_d = IDX_W'(bar1_q);
        end
`endif
      end
    end
  end

  // Stage 3: move tags and syncs alongside the palette lookup
  always_comb begin
    vld3_d = vld3_q;
    hs3_d  = hs3_q;
    vs3_d  = vs3_q;
    if (i_pix_stb) begin
      vld3_d = vld2_q;
      hs3_d  = hs2_q;
      vs3_d  = vs2_q;
    end
  end

  // Pipeline state; reset drops every in-flight pixel and marks all stages blank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr1_q  <= '0;
      rd_q     <= 1'b0;
      act1_q   <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
`ifdef VGA_FB_TEST_PATTERN_EN
      tm1_q    <= 1'b0;
      bar1_q   <= '0;
`endif
      rd_dly_q <= 1'b0;
      fb_cap_q <= '0;
      idx2_q   <= '0;
      vld2_q   <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      vld3_q   <= 1'b0;
      hs3_q    <= 1'b0;
      vs3_q    <= 1'b0;
    end else begin
      addr1_q  <= addr1_d;
      rd_q     <= rd_d;
      act1_q   <= act1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
`ifdef VGA_FB_TEST_PATTERN_EN
      tm1_q    <= tm1_d;
      bar1_q   <= bar1_d;
`endif
      rd_dly_q <= rd_dly_d;
      fb_cap_q <= fb_cap_d;
      idx2_q   <= idx2_d;
      vld2_q   <= vld2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      vld3_q   <= vld3_d;
      hs3_q    <= hs3_d;
      vs3_q    <= vs3_d;
    end
  end

  // The palette read register is the stage-3 colour; it only reads on a strobe
  vga_palette u_palette (
    .i_clk   (i_clk),
    .i_we    (i_pal_we),
    .i_waddr (i_pal_addr),
    .i_wdata (i_pal_data),
    .i_re    (i_pix_stb),
    .i_raddr (idx2_q),
    .o_rdata (pal_rgb)
  );

  // Blank pixels show black whatever palette[0] holds; vld3_q also blanks asynchronously in reset
  always_comb begin
    rgb_out = '0;
    if (vld3_q) begin
      rgb_out = pal_rgb;
    end
  end

  assign o_fb_addr = addr1_q;
  assign o_fb_rd   = rd_q;
  assign o_r       = rgb_out.r;
  assign o_g       = rgb_out.g;
  assign o_b       = rgb_out.b;
  assign o_hs      = hs3_q;
  assign o_vs      = vs3_q;

endmodule

// File: doc/vga_fb_reader.md
VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have port i_clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-003 SHALL have port i_pix_stb, input, 1, pixel strobe from the timing generator; asserts at most once every 2 i_clk.
REQ-004 SHALL have ports i_hs and i_vs, input, 1 each, raw syncs; i_active, input, 1, active-pixel flag.
REQ-005 SHALL have ports i_x and i_y, input, 10 each, current pixel position (0..639, 0..479).
REQ-006 SHALL have ports o_fb_addr, output, 17, and o_fb_rd, output, 1, framebuffer read request.
REQ-007 SHALL have port i_fb_data, input, 8, palette index, valid exactly 1 i_clk after o_fb_rd.
REQ-008 SHALL have ports i_pal_we, input, 1; i_pal_addr, input, 8; i_pal_data, input, 12 (RGB 4:4:4).
REQ-009 SHALL have ports o_r, o_g and o_b, output, 4 each, plus o_hs and o_vs, output, 1 each, aligned to RGB.

Function
REQ-010 SHALL advance its 3-stage pipeline only on i_clk edges where i_pix_stb=1; all stage registers SHALL hold otherwise.
REQ-011 Stage 1 SHALL compute o_fb_addr=(i_y>>1)*320+(i_x>>1) as a 17-bit value, using shift-add (y'<<8)+(y'<<6) with no multiplier; maximum value 76799.
REQ-012 o_fb_rd SHALL pulse for exactly one i_clk in the strobe cycle, only when i_active=1.
REQ-013 Stage 2 SHALL capture i_fb_data on the i_clk after o_fb_rd into an index register; when inactive, the index SHALL be forced to 0 and tagged blank.
REQ-014 Stage 3 SHALL look up the palette and drive o_r/o_g/o_b; blank-tagged pixels SHALL output 0/0/0 regardless of palette[0].
REQ-015 i_hs/i_vs SHALL pass through a 3-strobe delay line, so that o_hs/o_vs align with the RGB of the same pixel; polarity is unchanged.
REQ-016 Total latency SHALL be 3 pixel strobes from input pixel to output RGB.
REQ-017 A palette write SHALL take effect on the next i_clk; a simultaneous read of the same index SHALL return the old value.
REQ-018 Palette writes SHALL be accepted at any time, independent of i_pix_stb.

Reset
REQ-019 While i_rst_n=0, o_r/o_g/o_b SHALL be 0, o_hs/o_vs SHALL be 0, o_fb_rd SHALL be 0, o_fb_addr SHALL be 0, and all delay/tag registers SHALL be 0 (blank).
REQ-020 Palette contents SHALL NOT be reset.
REQ-021 Reset mid-frame SHALL drop in-flight pixels; output SHALL restart valid after 3 strobes following deassertion.

Configuration
REQ-022 With macro VGA_FB_TEST_PATTERN_EN defined, the block SHALL add input i_test_mode (1 bit). When it is high, the stage-2 index SHALL be replaced by i_x/80 (8 bars, index 0..7), the fb read SHALL be suppressed, and latency SHALL be unchanged.
REQ-023 Without the macro, the port and its logic SHALL be absent, and the behaviour SHALL be as in REQ-010..018.

Structure
REQ-024 Package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, FB_W=320, FB_H=240, PIPE_LAT=3, FB_AW=17, and typedef rgb444_t (struct r,g,b 4 bits).
REQ-025 The palette SHALL be a sub-module vga_palette: 256x12 array, 1 write port, 1 synchronous read port, no reset.

Verification
REQ-026 Write palette[0x12]=0xF80; preload fb[(10>>1)*320+(20>>1)=1610]=0x12; drive pixel (20,10) active -> o_fb_addr=1610, and 3 strobes later RGB=F/8/0.
REQ-027 Pixel (639,479) -> o_fb_addr=76799 with no overflow.
REQ-028 Inactive pixel, with palette[0]=0xFFF -> no o_fb_rd, RGB=0/0/0.
REQ-029 Toggle i_hs at strobe N -> o_hs toggles at strobe N+3; no change between strobes.
REQ-030 Write palette[5] in the same clock as the stage-3 read of index 5 -> old colour out; the next pixel with index 5 shows the new colour.
REQ-031 Assert i_rst_n=0 mid-line -> all outputs 0 asynchronously; after release, the first 3 strobes output blank; with VGA_FB_TEST_PATTERN_EN and i_test_mode=1, x=165 -> index 2.
